inert_rd_seq: RTL and testbench

- Command sequencer that sits directly upstream of the SPI monarch and feeds it. It drives the monarch's wrt/wt_data inputs and consumes its done/rd_data outputs.
- After reset it waits for the inertial sensor to power up, then writes four configuration registers.
- From then on, each time the sensor's data-ready interrupt is seen, it reads six bytes and presents pitch/roll/yaw rates as 16-bit words with a one-cycle valid pulse.

---
 rtl/inert_rd_seq.sv | 174 +++++++++++++++++
 tb/tb_inert_rd_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_rd_seq.sv
// inert_rd_seq: command sequencer in front of the SPI monarch for the
// inertial sensor. After reset it waits 2^PWRUP_W clocks, writes four
// configuration registers, then on each data-ready interrupt reads the
// rate bytes and presents ptch/roll/yaw with a one-cycle vld pulse.
// Optional build macro INERT_ACCEL_RD_EN adds the ax/ay reads and outputs.
module inert_rd_seq #(
  parameter int PWRUP_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
`ifdef INERT_ACCEL_RD_EN
  output logic [15:0] ax,
  output logic [15:0] ay,
`endif
  output logic        vld
);

`ifdef INERT_ACCEL_RD_EN
  localparam int unsigned IDX_W = 4;
  localparam int unsigned NRD   = 10;
`else
  localparam int unsigned IDX_W = 3;
  localparam int unsigned NRD   = 6;
`endif

  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(3);
  localparam logic [IDX_W-1:0] RD_LAST   = IDX_W'(NRD - 1);

  localparam logic [2:0] PWRUP    = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] INIT_W   = 3'd2;
  localparam logic [2:0] WAIT_INT = 3'd3;
  localparam logic [2:0] RD       = 3'd4;
  localparam logic [2:0] RD_W     = 3'd5;
  localparam logic [2:0] UPD      = 3'd6;

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [PWRUP_W-1:0] pwr_cnt;
  logic               int_s1;
  logic               int_s;
  logic               done_q;
  logic               done_rise;
  logic [7:0]         sh [NRD];
  logic               unused_rd_hi;

  // Only the low byte of the monarch read data carries a register value.
  assign unused_rd_hi = ^rd_data[15:8];

  // done stays high between transactions, so completion is its rising edge.
  assign done_rise = done & ~done_q;

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 16'h0D02;  // INT on data-ready
      2'd1:    init_cmd = 16'h1062;  // accel config
      2'd2:    init_cmd = 16'h1162;  // gyro config
      default: init_cmd = 16'h1460;  // rounding
    endcase
  endfunction

  // Read addresses are consecutive from 0xA2 (pitchL) upward.
  function automatic logic [15:0] rd_cmd(input logic [IDX_W-1:0] i);
    rd_cmd = {4'hA, 4'd2 + 4'(i), 8'h00};
  endfunction

  // Two-flop synchroniser for the asynchronous interrupt pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1 <= 1'b0;
      int_s  <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s  <= int_s1;
    end
  end

  // Delayed copy of done for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done;
  end

  // Sequencer: wrt and cmd are loaded on the transition into INIT/RD so the
  // pulse and its command word appear together during that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PWRUP;
      idx     <= '0;
      pwr_cnt <= '0;
      wrt     <= 1'b0;
      cmd     <= '0;
      ptch    <= '0;
      roll    <= '0;
      yaw     <= '0;
`ifdef INERT_ACCEL_RD_EN
      ax      <= '0;
      ay      <= '0;
`endif
      vld     <= 1'b0;
      for (int unsigned i = 0; i < NRD; i++) sh[i] <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWRUP: begin
          pwr_cnt <= pwr_cnt + 1'b1;
          if (&pwr_cnt) begin
            state <= INIT;
            idx   <= '0;
            wrt   <= 1'b1;
            cmd   <= init_cmd(2'd0);
          end
        end
        INIT: state <= INIT_W;
        INIT_W: begin
          if (done_rise) begin
            if (idx == INIT_LAST) begin
              state <= WAIT_INT;
            end else begin
              idx   <= idx + 1'b1;
              state <= INIT;
              wrt   <= 1'b1;
              cmd   <= init_cmd(2'(idx + 1'b1));
            end
          end
        end
        WAIT_INT: begin
          if (int_s) begin
            state <= RD;
            idx   <= '0;
            wrt   <= 1'b1;
            cmd   <= rd_cmd('0);
          end
        end
        RD: state <= RD_W;
        RD_W: begin
          if (done_rise) begin
            sh[idx] <= rd_data[7:0];
            if (idx == RD_LAST) begin
              state <= UPD;
            end else begin
              idx   <= idx + 1'b1;
              state <= RD;
              wrt   <= 1'b1;
              cmd   <= rd_cmd(idx + 1'b1);
            end
          end
        end
        UPD: begin
          ptch  <= {sh[1], sh[0]};
          roll  <= {sh[3], sh[2]};
          yaw   <= {sh[5], sh[4]};
`ifdef INERT_ACCEL_RD_EN
          ax    <= {sh[7], sh[6]};
          ay    <= {sh[9], sh[8]};
`endif
          vld   <= 1'b1;
          state <= WAIT_INT;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_rd_seq.sv
// Directed bench for inert_rd_seq with a behavioural SPI serf: done falls on
// wrt and rises 40 clocks later with the byte addressed by the command.
module tb_inert_rd_seq;
`ifdef INERT_ACCEL_RD_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic        vld;
  logic [15:0] cmd, ptch, roll, yaw;
`ifdef INERT_ACCEL_RD_EN
  logic [15:0] ax, ay;
`endif

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  inert_rd_seq #(.PWRUP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch(ptch), .roll(roll), .yaw(yaw),
`ifdef INERT_ACCEL_RD_EN
    .ax(ax), .ay(ay),
`endif
    .vld(vld)
  );

  // SPI serf model
  logic [7:0]  resp [0:15];
  logic        busy;
  int          scnt;
  logic [15:0] cur_cmd;
  int          proto_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0; busy <= 1'b0; scnt <= 0; cur_cmd <= '0; rd_data <= '0;
    end else if (wrt) begin
      if (busy) proto_err <= proto_err + 1;
      done <= 1'b0; busy <= 1'b1; scnt <= 39; cur_cmd <= cmd;
    end else if (busy) begin
      if (scnt == 0) begin
        done <= 1'b1; busy <= 1'b0;
        rd_data <= {8'h5A, (cur_cmd[15:12] == 4'hA) ? resp[cur_cmd[11:8] - 4'd2] : 8'h00};
      end else begin
        scnt <= scnt - 1;
      end
    end
  end

  // Monitors
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  int          drise_cnt = 0;
  logic        done_p = 1'b0;
  logic [15:0] cmd_log [$];

  always @(negedge clk) begin
    if (wrt) begin wrt_cnt++; cmd_log.push_back(cmd); end
    if (vld) vld_cnt++;
    if (done && !done_p) drise_cnt++;
    done_p = done;
  end

  task automatic test_reset();
    rst_n = 1'b0; INT = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b, expected 0", wrt); end
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h, expected 0000", cmd); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b, expected 0", vld); end
    checks++; if ({ptch, roll, yaw} !== 48'h0) begin errors++; $display("FAIL reset_outs: got %h, expected 0", {ptch, roll, yaw}); end
  endtask

  task automatic test_pwrup(input string tag);
    int n;
    int d0;
    cmd_log.delete();
    d0 = drise_cnt;
    rst_n = 1'b1;
    n = 0;
    while (!wrt && n < 100) begin @(negedge clk); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL %s_first_wrt_delay: got %0d, expected 16", tag, n); end
    n = 0;
    while (cmd_log.size() < 4 && n < 400) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    checks++; if (cmd_log.size() !== 4) begin errors++; $display("FAIL %s_init_wrt_count: got %0d, expected 4", tag, cmd_log.size()); end
    if (cmd_log.size() >= 4) begin
      checks++; if (cmd_log[0] !== 16'h0D02) begin errors++; $display("FAIL %s_init_cmd0: got %h, expected 0d02", tag, cmd_log[0]); end
      checks++; if (cmd_log[1] !== 16'h1062) begin errors++; $display("FAIL %s_init_cmd1: got %h, expected 1062", tag, cmd_log[1]); end
      checks++; if (cmd_log[2] !== 16'h1162) begin errors++; $display("FAIL %s_init_cmd2: got %h, expected 1162", tag, cmd_log[2]); end
      checks++; if (cmd_log[3] !== 16'h1460) begin errors++; $display("FAIL %s_init_cmd3: got %h, expected 1460", tag, cmd_log[3]); end
    end
    checks++; if (drise_cnt - d0 !== 4) begin errors++; $display("FAIL %s_init_done_rises: got %0d, expected 4", tag, drise_cnt - d0); end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL %s_wrt_while_busy: got %0d, expected 0", tag, proto_err); end
  endtask

  task automatic test_single_read();
    int n;
    int v0;
    resp[0] = 8'h34; resp[1] = 8'h12; resp[2] = 8'hCD;
    resp[3] = 8'hAB; resp[4] = 8'h01; resp[5] = 8'h80;
    cmd_log.delete();
    v0 = vld_cnt;
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 2000) begin @(negedge clk); n++; end
    repeat (80) @(negedge clk);
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL single_vld_count: got %0d, expected 1", vld_cnt - v0); end
    checks++; if (ptch !== 16'h1234) begin errors++; $display("FAIL single_ptch: got %h, expected 1234", ptch); end
    checks++; if (roll !== 16'hABCD) begin errors++; $display("FAIL single_roll: got %h, expected abcd", roll); end
    checks++; if (yaw !== 16'h8001) begin errors++; $display("FAIL single_yaw: got %h, expected 8001", yaw); end
    checks++; if (cmd_log.size() !== NRD) begin errors++; $display("FAIL single_wrt_count: got %0d, expected %0d", cmd_log.size(), NRD); end
    for (int i = 0; i < NRD && i < cmd_log.size(); i++) begin
      checks++;
      if (cmd_log[i] !== 16'hA200 + 16'(i << 8)) begin
        errors++; $display("FAIL single_cmd%0d: got %h, expected %h", i, cmd_log[i], 16'hA200 + 16'(i << 8));
      end
    end
  endtask

  task automatic test_atomic();
    int   n;
    logic early;
    logic seen;
    resp[0] = 8'h78; resp[1] = 8'h56; resp[2] = 8'hF0;
    resp[3] = 8'hDE; resp[4] = 8'hBC; resp[5] = 8'h9A;
    early = 1'b0; seen = 1'b0;
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (!seen && n < 2000) begin
      @(negedge clk); n++;
      if (vld) seen = 1'b1;
      else if (ptch !== 16'h1234 || roll !== 16'hABCD || yaw !== 16'h8001) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL atomic_hold_before_vld: got %b, expected 0", early); end
    checks++; if (ptch !== 16'h5678) begin errors++; $display("FAIL atomic_ptch: got %h, expected 5678", ptch); end
    checks++; if (roll !== 16'hDEF0) begin errors++; $display("FAIL atomic_roll: got %h, expected def0", roll); end
    checks++; if (yaw !== 16'h9ABC) begin errors++; $display("FAIL atomic_yaw: got %h, expected 9abc", yaw); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   n;
    int   nv;
    int   g;
    int   ng;
    int   gaps [3];
    logic armed;
    int   v0;
    int   w0;
    v0 = vld_cnt; w0 = wrt_cnt;
    nv = 0; ng = 0; g = 0; armed = 1'b0;
    for (int i = 0; i < 3; i++) gaps[i] = -1;
    INT = 1'b1;
    n = 0;
    while (nv < 4 && n < 5000) begin
      @(negedge clk); n++;
      if (vld) begin
        nv++; armed = 1'b1; g = 0;
        if (nv == 3) INT = 1'b0;
      end else if (armed) begin
        g++;
        if (wrt) begin
          if (ng < 3) gaps[ng] = g;
          ng++; armed = 1'b0;
        end
      end
    end
    INT = 1'b0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (gaps[i] !== 1) begin errors++; $display("FAIL b2b_gap%0d: got %0d, expected 1", i, gaps[i]); end
    end
    checks++; if (vld_cnt - v0 !== 4) begin errors++; $display("FAIL b2b_vld_count: got %0d, expected 4", vld_cnt - v0); end
    checks++; if (wrt_cnt - w0 !== 4 * NRD) begin errors++; $display("FAIL b2b_wrt_count: got %0d, expected %0d", wrt_cnt - w0, 4 * NRD); end
  endtask

  task automatic test_glitch();
    int n;
    int v0;
    int w0;
    v0 = vld_cnt; w0 = wrt_cnt;
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (wrt_cnt - w0 < 2 && n < 500) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 2000) begin @(negedge clk); n++; end
    repeat (150) @(negedge clk);
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL glitch_vld_count: got %0d, expected 1", vld_cnt - v0); end
    checks++; if (wrt_cnt - w0 !== NRD) begin errors++; $display("FAIL glitch_wrt_count: got %0d, expected %0d", wrt_cnt - w0, NRD); end
  endtask

`ifdef INERT_ACCEL_RD_EN
  task automatic test_accel();
    int n;
    int v0;
    int w0;
    resp[6] = 8'h10; resp[7] = 8'h00; resp[8] = 8'hF0; resp[9] = 8'hFF;
    v0 = vld_cnt; w0 = wrt_cnt;
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 3000) begin @(negedge clk); n++; end
    repeat (80) @(negedge clk);
    checks++; if (ax !== 16'h0010) begin errors++; $display("FAIL accel_ax: got %h, expected 0010", ax); end
    checks++; if (ay !== 16'hFFF0) begin errors++; $display("FAIL accel_ay: got %h, expected fff0", ay); end
    checks++; if (wrt_cnt - w0 !== 10) begin errors++; $display("FAIL accel_wrt_count: got %0d, expected 10", wrt_cnt - w0); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL accel_vld_count: got %0d, expected 1", vld_cnt - v0); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    int w0;
    w0 = wrt_cnt;
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    n = 0;
    while (wrt_cnt - w0 < 3 && n < 500) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL mid_reset_wrt: got %b, expected 0", wrt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b, expected 0", vld); end
    checks++; if (ptch !== 16'h0) begin errors++; $display("FAIL mid_reset_ptch: got %h, expected 0000", ptch); end
    checks++; if (roll !== 16'h0) begin errors++; $display("FAIL mid_reset_roll: got %h, expected 0000", roll); end
    checks++; if (yaw !== 16'h0) begin errors++; $display("FAIL mid_reset_yaw: got %h, expected 0000", yaw); end
    repeat (2) @(negedge clk);
    test_pwrup("mid");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    test_reset();
    test_pwrup("pwrup");
    test_single_read();
    test_atomic();
    test_back_to_back();
    test_glitch();
`ifdef INERT_ACCEL_RD_EN
    test_accel();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
